// File: rtl/rf_window_stack.sv
// LIFO window stack: captures 2*N-word spills and returns them reversed on fill.
// Latency: a fill request gives the first word two edges later, then one word per cycle.
// No backpressure. Requests that arrive while busy set proto_err and are ignored.
module rf_window_stack #(
    parameter int NBITS   = 64,
    parameter int N       = 3,
    parameter int MAX_WIN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rf_spill,
    input  logic                           rf_fill,
    input  logic [NBITS-1:0]               rf_mem_bus,
    input  logic                           clr_err,
    output logic [NBITS-1:0]               rf_mem_busRead,
    output logic                           fill_valid,
    output logic                           busy,
    output logic [$clog2(MAX_WIN+1)-1:0]   win_cnt,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           proto_err
);

    localparam int WORDS = 2 * N;
    localparam int DEPTH = MAX_WIN * WORDS;
    localparam int WP_W  = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BT_W  = $clog2(WORDS + 1);
    localparam int CW    = $clog2(MAX_WIN + 1);

    typedef enum logic [1:0] {IDLE, SPILL, DROP, FILL} state_t;

    state_t            state, state_nxt;
    logic [WP_W-1:0]   wp, wp_nxt, base_wp, wp_dec;
    logic [BT_W-1:0]   beat, beat_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              mem_we, rd_en;
    logic              ovf_set, unf_set, perr_set;
    logic              last_beat;
    logic [AW-1:0]     wr_idx, rd_idx;
    logic [NBITS-1:0]  mem [DEPTH];

    // An aborted spill rewinds to the top of the last complete window.
    assign base_wp   = WP_W'(win_cnt) * WP_W'(WORDS);
    assign wp_dec    = wp - WP_W'(1);
    assign wr_idx    = wp[AW-1:0];
    assign rd_idx    = wp_dec[AW-1:0];
    assign last_beat = (beat == BT_W'(WORDS - 1));

    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        beat_nxt  = beat;
        cnt_nxt   = win_cnt;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        perr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (rf_spill) begin
                    perr_set = rf_fill;
                    beat_nxt = BT_W'(1);
                    if (win_cnt == CW'(MAX_WIN)) begin
                        ovf_set   = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        mem_we    = 1'b1;
                        wp_nxt    = wp + WP_W'(1);
                        state_nxt = SPILL;
                    end
                end else if (rf_fill) begin
                    if (win_cnt == '0) begin
                        unf_set = 1'b1;
                    end else begin
                        state_nxt = FILL;
                        beat_nxt  = '0;
                    end
                end
            end
            SPILL: begin
                perr_set = rf_fill;
                if (!rf_spill) begin
                    perr_set  = 1'b1;
                    wp_nxt    = base_wp;
                    beat_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    mem_we   = 1'b1;
                    wp_nxt   = wp + WP_W'(1);
                    beat_nxt = beat + BT_W'(1);
                    if (last_beat) begin
                        cnt_nxt   = win_cnt + CW'(1);
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                perr_set = rf_fill;
                if (!rf_spill) begin
                    perr_set  = 1'b1;
                    wp_nxt    = base_wp;
                    beat_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    beat_nxt = beat + BT_W'(1);
                    if (last_beat) begin
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            FILL: begin
                perr_set = rf_spill | rf_fill;
                rd_en    = 1'b1;
                wp_nxt   = wp_dec;
                beat_nxt = beat + BT_W'(1);
                if (last_beat) begin
                    cnt_nxt   = win_cnt - CW'(1);
                    beat_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wp             <= '0;
            beat           <= '0;
            win_cnt        <= '0;
            busy           <= 1'b0;
            fill_valid     <= 1'b0;
            rf_mem_busRead <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wp         <= wp_nxt;
            beat       <= beat_nxt;
            win_cnt    <= cnt_nxt;
            busy       <= (state_nxt != IDLE);
            fill_valid <= rd_en;
            if (rd_en) begin
                rf_mem_busRead <= mem[rd_idx];
            end
            // A new error in the clearing cycle keeps its flag set.
            overflow  <= (overflow  & ~clr_err) | ovf_set;
            underflow <= (underflow & ~clr_err) | unf_set;
            proto_err <= (proto_err & ~clr_err) | perr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= rf_mem_bus;
        end
    end

endmodule

// File: tb/tb_rf_window_stack.sv
// Bench for rf_window_stack: directed plus random spill/fill traffic against a word-queue stack model.
module tb_rf_window_stack;

    localparam int NB = 64;
    localparam int N  = 3;
    localparam int MW = 2;
    localparam int W  = 2 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rf_spill = 1'b0;
    logic          rf_fill = 1'b0;
    logic          clr_err = 1'b0;
    logic [NB-1:0] rf_mem_bus = '0;
    logic [NB-1:0] rf_mem_busRead;
    logic          fill_valid, busy;
    logic [1:0]    win_cnt;
    logic          overflow, underflow, proto_err;

    rf_window_stack #(.NBITS(NB), .N(N), .MAX_WIN(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rf_spill       (rf_spill),
        .rf_fill        (rf_fill),
        .rf_mem_bus     (rf_mem_bus),
        .clr_err        (clr_err),
        .rf_mem_busRead (rf_mem_busRead),
        .fill_valid     (fill_valid),
        .busy           (busy),
        .win_cnt        (win_cnt),
        .overflow       (overflow),
        .underflow      (underflow),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a plain queue of words, newest word at the back.
    logic [63:0] stk[$];
    logic [63:0] last_rd;
    bit          m_ovf, m_unf, m_perr;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle();
        chk("win_cnt", 64'(win_cnt), 64'(stk.size() / W));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("proto_err", 64'(proto_err), 64'(m_perr));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_valid", 64'(fill_valid), 64'(0));
    endtask

    // nb beats of spill; the fill request is raised on beat cidx (negative = never).
    task automatic do_spill(input int nb, input logic [63:0] base, input bit rnd, input int cidx);
        logic [63:0] d[W];
        bit full;
        full = (stk.size() == MW * W);
        for (int i = 0; i < W; i++) d[i] = rnd ? {$urandom(), $urandom()} : base + 64'(i);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i > 0) chk("spill_busy", 64'(busy), 64'(1));
            rf_spill   = 1'b1;
            rf_mem_bus = d[i];
            rf_fill    = (i == cidx);
        end
        @(negedge clk);
        rf_spill   = 1'b0;
        rf_fill    = 1'b0;
        rf_mem_bus = {$urandom(), $urandom()};
        if (nb < W) begin
            chk("abort_busy", 64'(busy), 64'(1));
            @(negedge clk);
        end
        if (full) m_ovf = 1'b1;
        if ((cidx >= 0 && cidx < nb) || nb < W) m_perr = 1'b1;
        if (!full && nb == W) for (int i = 0; i < W; i++) stk.push_back(d[i]);
        chk_idle();
    endtask

    task automatic do_fill();
        int n;
        n = stk.size();
        @(negedge clk);
        rf_fill = 1'b1;
        @(negedge clk);
        rf_fill = 1'b0;
        if (n == 0) begin
            m_unf = 1'b1;
            chk("unf_flag", 64'(underflow), 64'(1));
            for (int i = 0; i < W + 2; i++) begin
                chk("unf_novalid", 64'(fill_valid), 64'(0));
                @(negedge clk);
            end
        end else begin
            chk("fill_latency", 64'(fill_valid), 64'(0));
            chk("fill_busy", 64'(busy), 64'(1));
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                chk("fill_valid", 64'(fill_valid), 64'(1));
                chk("fill_data", rf_mem_busRead, stk[$]);
                last_rd = stk.pop_back();
            end
            @(negedge clk);
            chk("fill_hold", rf_mem_busRead, last_rd);
        end
        chk_idle();
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_perr = 1'b0;
        chk_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        last_rd = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle();
        chk("reset_data", rf_mem_busRead, 64'(0));
        rst = 1'b1;

        // Single window round trip.
        do_spill(W, 64'h10, 1'b0, -1);
        do_fill();

        // Fill to capacity, overflow on the third window, unwind in LIFO order.
        do_spill(W, 64'hA0, 1'b0, -1);
        do_spill(W, 64'hB0, 1'b0, -1);
        do_spill(W, 64'hC0, 1'b0, -1);
        do_fill();
        do_fill();
        do_clr();

        // Empty fill, then clear.
        do_fill();
        do_clr();

        // Truncated spill is discarded; next full spill must read back intact.
        do_spill(3, 64'h30, 1'b0, -1);
        do_spill(W, 64'h40, 1'b0, -1);
        do_fill();
        do_clr();

        // Request collisions: simultaneous with the first beat, and mid-spill.
        do_spill(W, 64'h0, 1'b1, 0);
        do_spill(W, 64'h0, 1'b1, 3);
        do_fill();
        do_fill();
        do_clr();

        repeat (16) begin
            case ($urandom_range(0, 3))
                0: do_spill(W, 64'h0, 1'b1, -1);
                1: do_spill($urandom_range(1, W), 64'h0, 1'b1, -1);
                2: do_fill();
                default: do_clr();
            endcase
        end

        // Asynchronous reset in the middle of a fill.
        if (stk.size() == 0) do_spill(W, 64'h0, 1'b1, -1);
        @(negedge clk);
        rf_fill = 1'b1;
        @(negedge clk);
        rf_fill = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 64'(fill_valid), 64'(1));
        rst = 1'b0;
        #1;
        stk.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_perr = 1'b0;
        chk_idle();
        chk("rst_data", rf_mem_busRead, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        do_fill();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
